// File: rtl/aes_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_bytes_iter
// Function : Iterative AES SubBytes on a 128-bit state, LANES lookups/cycle.
//            Define AES_SUB_BYTES_INV_EN to add the inv port (InvSubBytes).
// Revision : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
`ifdef AES_SUB_BYTES_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] block,
    output logic         ready,
    output logic [127:0] result,
    output logic         result_valid
);

    localparam int c_n     = 16 / LANES;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cnt_w-1:0] c_last_grp = c_cnt_w'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Table row-major: entry x sits at bit offset 8*(255-x).
    localparam logic [2047:0] c_sbox_fwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return c_sbox_fwd[{~x, 3'b000} +: 8];
    endfunction

`ifdef AES_SUB_BYTES_INV_EN
    localparam logic [2047:0] c_sbox_inv = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return c_sbox_inv[{~x, 3'b000} +: 8];
    endfunction

    logic r_inv;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [127:0]       r_data;
    logic [127:0]       w_next_data;
    logic               w_accept;
    logic               w_last;
    logic [4:0]         w_base;
    logic [6:0]         w_off [LANES];
    logic [7:0]         w_sub [LANES];

    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_last   = (r_cnt == c_last_grp);
    assign w_base   = 5'(r_cnt) * 5'(LANES);

    // Byte k of the state lives at bits [127-8k -: 8].
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_off[l] = 7'(8 * (15 - int'(w_base) - l));
`ifdef AES_SUB_BYTES_INV_EN
        assign w_sub[l] = r_inv ? sbox_inv(r_data[w_off[l] +: 8])
                                : sbox_fwd(r_data[w_off[l] +: 8]);
`else
        assign w_sub[l] = sbox_fwd(r_data[w_off[l] +: 8]);
`endif
    end

    always_comb begin
        w_next_data = r_data;
        for (int i = 0; i < LANES; i++) begin
            w_next_data[w_off[i] +: 8] = w_sub[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: if (w_accept) w_state_nxt = c_st_busy;
            c_st_busy:            if (w_last)   w_state_nxt = c_st_done;
            default:              w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        ready        = 1'b1;
        result_valid = 1'b0;
        case (r_state)
            c_st_busy: ready        = 1'b0;
            c_st_done: result_valid = 1'b1;
            default: ;
        endcase
    end

    // Counter holds at the last group so it can never wrap while busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= block;
            r_cnt  <= '0;
        end else if (r_state == c_st_busy) begin
            r_data <= w_next_data;
            if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef AES_SUB_BYTES_INV_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= inv;
        end
    end
`endif

    assign result = r_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sub_bytes_iter
// Function : Directed bench for aes_sub_bytes_iter at LANES = 4, 1 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sub_bytes_iter;

    typedef struct {
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start4, start1, start16;
    logic [127:0] block;
`ifdef AES_SUB_BYTES_INV_EN
    logic         inv;
`endif
    logic         ready4, ready1, ready16;
    logic         valid4, valid1, valid16;
    logic [127:0] res4, res1, res16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_iter #(.LANES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4),
`ifdef AES_SUB_BYTES_INV_EN
        .inv(inv),
`endif
        .block(block), .ready(ready4), .result(res4), .result_valid(valid4)
    );

    aes_sub_bytes_iter #(.LANES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
`ifdef AES_SUB_BYTES_INV_EN
        .inv(inv),
`endif
        .block(block), .ready(ready1), .result(res1), .result_valid(valid1)
    );

    aes_sub_bytes_iter #(.LANES(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16),
`ifdef AES_SUB_BYTES_INV_EN
        .inv(inv),
`endif
        .block(block), .ready(ready16), .result(res16), .result_valid(valid16)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input int which);
        case (which)
            1:       return valid1;
            16:      return valid16;
            default: return valid4;
        endcase
    endfunction

    function automatic logic get_ready(input int which);
        case (which)
            1:       return ready1;
            16:      return ready16;
            default: return ready4;
        endcase
    endfunction

    function automatic logic [127:0] get_result(input int which);
        case (which)
            1:       return res1;
            16:      return res16;
            default: return res4;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            1:       start1  = v;
            16:      start16 = v;
            default: start4  = v;
        endcase
    endtask

    // n counts rising edges since the capturing edge; bounded at 40.
    task automatic wait_valid(input int which, input int n0, output int n);
        n = n0;
        while (!get_valid(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic launch(input int which, input logic [127:0] b, output int n);
        @(negedge clk);
        block = b;
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        wait_valid(which, 0, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t         vecs [5];
        int           lanes [3];
        int           lat;
        logic [127:0] rnd;
        logic [127:0] fwd;
        logic [127:0] saved;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[1] = '{128'h0, {16{8'h63}}};
        vecs[2] = '{{16{8'h01}}, {16{8'h7c}}};
        vecs[3] = '{128'h0123456789abcdeffedcba9876543210, 128'h7c266e85a762bddfbb86f446382023ca};
        vecs[4] = '{128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 128'h8cf8b52e8d069017bcf9beb3ebd87276};
        lanes[0] = 4;
        lanes[1] = 1;
        lanes[2] = 16;

        reset_n = 1'b0;
        start4  = 1'b0;
        start1  = 1'b0;
        start16 = 1'b0;
        block   = '0;
`ifdef AES_SUB_BYTES_INV_EN
        inv     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_ready",  128'(ready4), 128'd1);
        check("reset_valid",  128'(valid4), 128'd0);
        check("reset_result", res4, 128'h0);
        check("reset_result_l1",  res1,  128'h0);
        check("reset_result_l16", res16, 128'h0);
        reset_n = 1'b1;

        // Every vector on every lane count; each start after the first lands in DONE.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                launch(lanes[k], vecs[i].blk, lat);
                check($sformatf("lat_l%0d_v%0d", lanes[k], i), 128'(lat), 128'(16 / lanes[k]));
                check($sformatf("res_l%0d_v%0d", lanes[k], i), get_result(lanes[k]), vecs[i].exp);
                check($sformatf("rdy_l%0d_v%0d", lanes[k], i), 128'(get_ready(lanes[k])), 128'd1);
                repeat (3) @(negedge clk);
                check($sformatf("hold_l%0d_v%0d", lanes[k], i), get_result(lanes[k]), vecs[i].exp);
                check($sformatf("hold_vld_l%0d_v%0d", lanes[k], i), 128'(get_valid(lanes[k])), 128'd1);
            end
        end

        // Group order: after one busy edge only bytes 0..3 are substituted.
        @(negedge clk);
        block  = 128'h00112233445566778899aabbccddeeff;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("busy_ready", 128'(ready4), 128'd0);
        check("busy_valid", 128'(valid4), 128'd0);
        @(negedge clk);
        check("partial_grp0", res4, 128'h638293c3445566778899aabbccddeeff);
        wait_valid(4, 1, lat);
        check("partial_lat", 128'(lat), 128'd4);
        check("partial_res", res4, 128'h638293c31bfc33f5c4eeacea4bc12816);

        // Start held into BUSY with different data must be ignored.
        @(negedge clk);
        block  = '0;
        start4 = 1'b1;
        @(negedge clk);
        block  = {128{1'b1}};
        @(negedge clk);
        start4 = 1'b0;
        wait_valid(4, 1, lat);
        check("ignore_lat", 128'(lat), 128'd4);
        check("ignore_res", res4, {16{8'h63}});

        // Reset during the second busy cycle aborts with nothing reported.
        @(negedge clk);
        block  = 128'h00112233445566778899aabbccddeeff;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_valid",  128'(valid4), 128'd0);
        check("abort_result", res4, 128'h0);
        check("abort_ready",  128'(ready4), 128'd1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_late_valid", 128'(valid4), 128'd0);
        launch(4, {16{8'h01}}, lat);
        check("post_abort_lat", 128'(lat), 128'd4);
        check("post_abort_res", res4, {16{8'h7c}});

`ifdef AES_SUB_BYTES_INV_EN
        inv = 1'b1;
        launch(4, 128'h638293c31bfc33f5c4eeacea4bc12816, lat);
        inv = 1'b0;
        check("inv_lat", 128'(lat), 128'd4);
        check("inv_res", res4, 128'h00112233445566778899aabbccddeeff);
        for (int r = 0; r < 3; r++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            saved = rnd;
            inv = 1'b0;
            launch(4, rnd, lat);
            fwd = res4;
            inv = 1'b1;
            launch(4, fwd, lat);
            inv = 1'b0;
            check($sformatf("roundtrip_%0d", r), res4, saved);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes_iter.md
AES_SUB_BYTES_ITER -- requirements
Module: aes_sub_bytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4: S-box lookups per cycle; legal values 1, 2, 4, 8, 16; N = 16/LANES.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request to substitute block; single-cycle pulse expected.
REQ-005 SHALL have port block, input, 128: state to substitute; byte 0 = block[127:120], byte 15 = block[7:0].
REQ-006 SHALL have port ready, output, 1: high when start will be accepted.
REQ-007 SHALL have port result, output, 128: substituted state, same byte ordering as block.
REQ-008 SHALL have port result_valid, output, 1: result holds a complete substituted block.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-010 SHALL set ready=1 in IDLE and DONE, and ready=0 in BUSY.
REQ-011 SHALL, on an edge with start=1 and ready=1: capture block into the working register, clear the byte-group counter, clear result_valid and enter BUSY.
REQ-012 SHALL, on each BUSY edge, replace LANES bytes in place with their FIPS-197 forward S-box values, in group order starting at byte 0 and proceeding to byte 15, then increment the counter.
REQ-013 SHALL, on the edge that processes the last group (counter = N-1), enter DONE with ready=1 and result_valid=1; result_valid rises exactly N edges after the capturing edge.
REQ-014 SHALL ignore start in BUSY, with no effect on state, counter or data.
REQ-015 SHALL hold result and result_valid stable in DONE until the next accepted start.
REQ-016 SHALL accept a start in DONE exactly like one in IDLE, so back-to-back blocks cost N+1 cycles each.
REQ-017 SHALL drive result as the working register at all times; its value is defined only while result_valid=1.
REQ-018 SHALL have the counter width ceil(log2(N)), minimum 1, and it SHALL never wrap in BUSY.
REQ-019 SHALL, with LANES=16, complete in one BUSY cycle (N=1).
REQ-020 SHALL contain no combinational path from start or block to any output.

Reset
REQ-021 SHALL, on an edge with reset_n=0, set state to IDLE, counter to 0, working register to 0, result_valid to 0 and ready to 1; reset takes priority over start.
REQ-022 SHALL, if reset occurs in BUSY or DONE, abort the operation with no partial result reported; the first start after reset_n returns high SHALL be accepted.

Configuration
REQ-023 SHALL, with AES_SUB_BYTES_INV_EN defined, add input port inv (1 bit), sampled with start and held in a register for the operation; inv=1 SHALL select the FIPS-197 inverse S-box for all bytes, and the register SHALL reset to 0.
REQ-024 SHALL, with AES_SUB_BYTES_INV_EN undefined, have no inv port, use the forward S-box only, and instantiate no inverse S-box logic.

Verification
REQ-025 SHALL verify: reset_n=0 for 2 cycles -> ready=1, result_valid=0, result=0.
REQ-026 SHALL verify with LANES=4: block=00112233445566778899aabbccddeeff, start pulse -> result_valid rises 4 edges later, result=638293c31bfc33f5c4eeacea4bc12816, ready=1.
REQ-027 SHALL verify: block=0, then start pulsed again while BUSY with block=ffff..ff -> result=6363..63 (all 16 bytes 0x63), second start ignored.
REQ-028 SHALL verify: reset_n=0 asserted on the second BUSY cycle -> next edge state IDLE, result_valid=0, result=0; subsequent start with block=0101..01 -> result=7c7c..7c.
REQ-029 SHALL verify with AES_SUB_BYTES_INV_EN: inv=1, block=638293c31bfc33f5c4eeacea4bc12816 -> result=00112233445566778899aabbccddeeff; random forward then inverse returns the original block.
REQ-030 SHALL verify for LANES in {1, 16}: block=00112233445566778899aabbccddeeff -> same result as REQ-026, with result_valid latency 16 and 1 edges respectively.
